// File: rtl/instr_regfile_alu_pipe.sv
// instr_regfile_alu_pipe
//   Two-stage pipelined instruction register file. A write request is
//   captured in S1, its signed result is computed in S2 and the entry
//   {opcode, operand_a, operand_b, result, div_err} is stored at the end
//   of S2. Reads are registered and qualified by a one-cycle rd_valid.
//   Each entry carries a written-since-reset flag, and entries_used counts
//   distinct entries written since reset.
//
// Parameters
//   OP_WIDTH  operand width (two's-complement signed)
//   DEPTH     number of entries, >= 2, any value
//   AW        pointer width, derived from DEPTH
//
// Ports
//   clk            clock, all state changes on posedge
//   reset_n        asynchronous active-low reset
//   load_en        write request
//   opcode         ZERO/PASSA/PASSB/ADD/SUB/MULT/DIV/MOD (0..7)
//   operand_a/b    signed operands
//   write_pointer  destination entry
//   read_en        read request
//   read_pointer   source entry
//   rd_valid       read data valid, one cycle after read_en
//   rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_div_err, rd_written
//                  stored fields of the entry read
//   wr_err         one-cycle pulse when a write targets an entry >= DEPTH
//   entries_used   distinct entries written since reset

module instr_regfile_alu_pipe #(
  parameter int OP_WIDTH = 32,
  parameter int DEPTH    = 32,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_en,
  input  logic [2:0]            opcode,
  input  logic [OP_WIDTH-1:0]   operand_a,
  input  logic [OP_WIDTH-1:0]   operand_b,
  input  logic [AW-1:0]         write_pointer,
  input  logic                  read_en,
  input  logic [AW-1:0]         read_pointer,
  output logic                  rd_valid,
  output logic [2:0]            rd_opcode,
  output logic [OP_WIDTH-1:0]   rd_operand_a,
  output logic [OP_WIDTH-1:0]   rd_operand_b,
  output logic [2*OP_WIDTH-1:0] rd_result,
  output logic                  rd_div_err,
  output logic                  rd_written,
  output logic                  wr_err,
  output logic [AW:0]           entries_used
);

  localparam int RW = 2 * OP_WIDTH;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    OP_ZERO  = 3'd0,
    OP_PASSA = 3'd1,
    OP_PASSB = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_MULT  = 3'd5,
    OP_DIV   = 3'd6,
    OP_MOD   = 3'd7
  } opcode_e;

  // S1 pipeline registers
  logic                s1_valid;
  logic [2:0]          s1_opcode;
  logic [OP_WIDTH-1:0] s1_a;
  logic [OP_WIDTH-1:0] s1_b;
  logic [AW-1:0]       s1_ptr;

  // S2 combinational results
  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;
  logic [RW-1:0]        s2_result;
  logic                 s2_div_err;
  logic                 s2_in_range;
  logic                 s2_we;
  logic                 rd_in_range;

  // Storage array
  logic [2:0]          mem_opcode  [DEPTH];
  logic [OP_WIDTH-1:0] mem_a       [DEPTH];
  logic [OP_WIDTH-1:0] mem_b       [DEPTH];
  logic [RW-1:0]       mem_result  [DEPTH];
  logic                mem_div_err [DEPTH];
  logic                written     [DEPTH];

  // S1: capture the request. Clearing s1_valid on reset guarantees a write
  // caught in S1 when reset arrives never reaches the array afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_ptr    <= '0;
    end else begin
      s1_valid <= load_en;
      if (load_en) begin
        s1_opcode <= opcode;
        s1_a      <= operand_a;
        s1_b      <= operand_b;
        s1_ptr    <= write_pointer;
      end
    end
  end

  // S2: everything is done at double width so ADD/SUB/MULT cannot overflow.
  // Division by zero is steered away from the divider so no X escapes.
  always_comb begin
    a_ext      = {{OP_WIDTH{s1_a[OP_WIDTH-1]}}, s1_a};
    b_ext      = {{OP_WIDTH{s1_b[OP_WIDTH-1]}}, s1_b};
    s2_result  = '0;
    s2_div_err = 1'b0;
    case (s1_opcode)
      OP_ZERO:  s2_result = '0;
      OP_PASSA: s2_result = a_ext;
      OP_PASSB: s2_result = b_ext;
      OP_ADD:   s2_result = a_ext + b_ext;
      OP_SUB:   s2_result = a_ext - b_ext;
      OP_MULT:  s2_result = a_ext * b_ext;
      OP_DIV: begin
        if (b_ext == '0) s2_div_err = 1'b1;
        else             s2_result  = a_ext / b_ext;
      end
      OP_MOD: begin
        if (b_ext == '0) s2_div_err = 1'b1;
        else             s2_result  = a_ext % b_ext;
      end
      default: s2_result = '0;
    endcase
  end

  always_comb begin
    s2_in_range = ({1'b0, s1_ptr} < DEPTH_CNT);
    s2_we       = s1_valid && s2_in_range;
    rd_in_range = ({1'b0, read_pointer} < DEPTH_CNT);
  end

  // Array write at the end of S2, together with the written flags and the
  // occupancy count. Only a first write to an entry bumps entries_used.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_opcode[i]  <= '0;
        mem_a[i]       <= '0;
        mem_b[i]       <= '0;
        mem_result[i]  <= '0;
        mem_div_err[i] <= 1'b0;
        written[i]     <= 1'b0;
      end
      entries_used <= '0;
      wr_err       <= 1'b0;
    end else begin
      wr_err <= s1_valid && !s2_in_range;
      if (s2_we) begin
        mem_opcode[s1_ptr]  <= s1_opcode;
        mem_a[s1_ptr]       <= s1_a;
        mem_b[s1_ptr]       <= s1_b;
        mem_result[s1_ptr]  <= s2_result;
        mem_div_err[s1_ptr] <= s2_div_err;
        written[s1_ptr]     <= 1'b1;
        if (!written[s1_ptr] && (entries_used < DEPTH_CNT)) begin
          entries_used <= entries_used + 1'b1;
        end
      end
    end
  end

  // Registered read port. It samples the array before the same-edge write
  // lands, so a colliding read returns the old contents. Out-of-range reads
  // still strobe rd_valid but return zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid     <= 1'b0;
      rd_opcode    <= '0;
      rd_operand_a <= '0;
      rd_operand_b <= '0;
      rd_result    <= '0;
      rd_div_err   <= 1'b0;
      rd_written   <= 1'b0;
    end else begin
      rd_valid <= read_en;
      if (read_en) begin
        if (rd_in_range) begin
          rd_opcode    <= mem_opcode[read_pointer];
          rd_operand_a <= mem_a[read_pointer];
          rd_operand_b <= mem_b[read_pointer];
          rd_result    <= mem_result[read_pointer];
          rd_div_err   <= mem_div_err[read_pointer];
          rd_written   <= written[read_pointer];
        end else begin
          rd_opcode    <= '0;
          rd_operand_a <= '0;
          rd_operand_b <= '0;
          rd_result    <= '0;
          rd_div_err   <= 1'b0;
          rd_written   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_regfile_alu_pipe.sv
// tb_instr_regfile_alu_pipe
//   Directed testbench for instr_regfile_alu_pipe (OP_WIDTH=32, DEPTH=12 so
//   that out-of-range pointers are reachable). Each scenario task drives
//   the DUT and compares outputs against hand-computed values.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a cycle away from the active rising edge.

module tb_instr_regfile_alu_pipe;

  localparam int OPW = 32;
  localparam int DEP = 12;
  localparam int AWT = 4;

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_MOD   = 3'd7;

  logic              clk;
  logic              reset_n;
  logic              load_en;
  logic [2:0]        opcode;
  logic [OPW-1:0]    operand_a;
  logic [OPW-1:0]    operand_b;
  logic [AWT-1:0]    write_pointer;
  logic              read_en;
  logic [AWT-1:0]    read_pointer;
  logic              rd_valid;
  logic [2:0]        rd_opcode;
  logic [OPW-1:0]    rd_operand_a;
  logic [OPW-1:0]    rd_operand_b;
  logic [2*OPW-1:0]  rd_result;
  logic              rd_div_err;
  logic              rd_written;
  logic              wr_err;
  logic [AWT:0]      entries_used;

  int n_compared;
  int n_mismatched;

  instr_regfile_alu_pipe #(
    .OP_WIDTH(OPW),
    .DEPTH(DEP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load_en(load_en),
    .opcode(opcode),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .write_pointer(write_pointer),
    .read_en(read_en),
    .read_pointer(read_pointer),
    .rd_valid(rd_valid),
    .rd_opcode(rd_opcode),
    .rd_operand_a(rd_operand_a),
    .rd_operand_b(rd_operand_b),
    .rd_result(rd_result),
    .rd_div_err(rd_div_err),
    .rd_written(rd_written),
    .wr_err(wr_err),
    .entries_used(entries_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one write for one rising edge; returns on the next falling edge.
  task automatic do_write(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] ptr);
    load_en       = 1'b1;
    opcode        = op;
    operand_a     = a;
    operand_b     = b;
    write_pointer = ptr;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Drive one read; on return the registered read data is on rd_*.
  task automatic do_read(input logic [3:0] ptr);
    read_en      = 1'b1;
    read_pointer = ptr;
    @(negedge clk);
    read_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [133:0] got;
    logic [133:0] exp_v;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_compared++;
    if (entries_used !== 5'd0 || rd_valid !== 1'b0 || wr_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got used=%0d valid=%b wr_err=%b expected 0/0/0",
               entries_used, rd_valid, wr_err);
    end
    exp_v = {1'b1, 133'b0};
    for (int i = 0; i < DEP; i++) begin
      do_read(4'(i));
      got = {rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_div_err, rd_written};
      n_compared++;
      if (got !== exp_v) begin
        n_mismatched++;
        $display("[TB] FAIL reset_read[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_add;
    do_write(OP_ADD, 32'hFFFF_FFFB, 32'd3, 4'd4);
    @(negedge clk);
    do_read(4'd4);
    n_compared++;
    if (rd_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_mismatched++;
      $display("[TB] FAIL add_result: got %h expected %h", rd_result, 64'hFFFF_FFFF_FFFF_FFFE);
    end
    n_compared++;
    if ({rd_valid, rd_written, rd_opcode, rd_operand_a, rd_operand_b, entries_used} !==
        {1'b1, 1'b1, OP_ADD, 32'hFFFF_FFFB, 32'd3, 5'd1}) begin
      n_mismatched++;
      $display("[TB] FAIL add_fields: got v=%b w=%b op=%0d a=%h b=%h used=%0d expected 1/1/3/fffffffb/3/1",
               rd_valid, rd_written, rd_opcode, rd_operand_a, rd_operand_b, entries_used);
    end
  endtask

  task automatic test_arith;
    logic [2:0]  ops  [8] = '{OP_MULT, OP_DIV, OP_MOD, OP_DIV, OP_MOD, OP_SUB, OP_PASSA, OP_ZERO};
    logic [31:0] as   [8] = '{32'h7FFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                              32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] bs   [8] = '{32'd2, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                              32'd3, 32'd7, 32'd5};
    logic [3:0]  ptrs [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd8, 4'd10};
    logic [63:0] exps [8] = '{64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD,
                              64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFF8,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};
    for (int i = 0; i < 8; i++) do_write(ops[i], as[i], bs[i], ptrs[i]);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      do_read(ptrs[i]);
      n_compared++;
      if ({rd_result, rd_div_err, rd_written} !== {exps[i], 1'b0, 1'b1}) begin
        n_mismatched++;
        $display("[TB] FAIL arith[%0d]: got res=%h err=%b w=%b expected res=%h err=0 w=1",
                 i, rd_result, rd_div_err, rd_written, exps[i]);
      end
    end
    n_compared++;
    if (entries_used !== 5'd9) begin
      n_mismatched++;
      $display("[TB] FAIL arith_used: got %0d expected 9", entries_used);
    end
  endtask

  task automatic test_div_zero;
    do_write(OP_DIV, 32'd9, 32'd0, 4'd11);
    @(negedge clk);
    do_read(4'd11);
    n_compared++;
    if ({rd_result, rd_div_err, rd_written} !== {64'd0, 1'b1, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL div_zero: got res=%h err=%b w=%b expected res=0 err=1 w=1",
               rd_result, rd_div_err, rd_written);
    end
    do_write(OP_MOD, 32'hFFFF_FFFC, 32'd0, 4'd11);
    @(negedge clk);
    do_read(4'd11);
    n_compared++;
    if ({rd_opcode, rd_result, rd_div_err} !== {OP_MOD, 64'd0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL mod_zero: got op=%0d res=%h err=%b expected op=7 res=0 err=1",
               rd_opcode, rd_result, rd_div_err);
    end
    do_write(OP_PASSB, 32'd9, 32'd6, 4'd11);
    @(negedge clk);
    do_read(4'd11);
    n_compared++;
    if ({rd_opcode, rd_operand_a, rd_result, rd_div_err, entries_used} !==
        {OP_PASSB, 32'd9, 64'd6, 1'b0, 5'd10}) begin
      n_mismatched++;
      $display("[TB] FAIL overwrite: got op=%0d a=%h res=%h err=%b used=%0d expected 2/9/6/0/10",
               rd_opcode, rd_operand_a, rd_result, rd_div_err, entries_used);
    end
  endtask

  task automatic test_same_cycle;
    do_write(OP_PASSA, 32'd100, 32'd0, 4'd7);
    @(negedge clk);
    do_write(OP_PASSA, 32'd200, 32'd0, 4'd7);
    do_read(4'd7);
    n_compared++;
    if (rd_result !== 64'd100) begin
      n_mismatched++;
      $display("[TB] FAIL collide_old: got %h expected %h", rd_result, 64'd100);
    end
    do_read(4'd7);
    n_compared++;
    if (rd_result !== 64'd200 || entries_used !== 5'd11) begin
      n_mismatched++;
      $display("[TB] FAIL collide_new: got res=%h used=%0d expected res=%h used=11",
               rd_result, entries_used, 64'd200);
    end
    @(negedge clk);
    n_compared++;
    if (rd_valid !== 1'b0 || rd_operand_a !== 32'd200) begin
      n_mismatched++;
      $display("[TB] FAIL read_hold: got valid=%b a=%h expected valid=0 a=%h",
               rd_valid, rd_operand_a, 32'd200);
    end
  endtask

  task automatic test_bounds;
    do_write(OP_ADD, 32'd1, 32'd1, 4'd13);
    n_compared++;
    if (wr_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL wr_err_early: got %b expected 0", wr_err);
    end
    @(negedge clk);
    n_compared++;
    if (wr_err !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL wr_err_pulse: got %b expected 1", wr_err);
    end
    @(negedge clk);
    n_compared++;
    if (wr_err !== 1'b0 || entries_used !== 5'd11) begin
      n_mismatched++;
      $display("[TB] FAIL wr_err_end: got wr_err=%b used=%0d expected 0/11", wr_err, entries_used);
    end
    do_read(4'd4);
    do_read(4'd13);
    n_compared++;
    if ({rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_div_err, rd_written} !==
        {1'b1, 133'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL read_oob: got v=%b op=%0d a=%h b=%h res=%h err=%b w=%b expected valid=1 rest 0",
               rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_div_err, rd_written);
    end
    do_read(4'd4);
    do_read(4'd9);
    n_compared++;
    if ({rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_div_err, rd_written} !==
        {1'b1, 133'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL read_unwritten: got v=%b op=%0d a=%h res=%h w=%b expected valid=1 rest 0",
               rd_valid, rd_opcode, rd_operand_a, rd_result, rd_written);
    end
  endtask

  task automatic test_reset_mid;
    do_write(OP_PASSA, 32'd55, 32'd0, 4'd9);
    reset_n = 1'b0;
    #1;
    n_compared++;
    if (entries_used !== 5'd0 || rd_operand_a !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got used=%0d a=%h expected 0/0", entries_used, rd_operand_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    do_read(4'd9);
    n_compared++;
    if ({rd_valid, rd_operand_a, rd_result, rd_written, entries_used} !==
        {1'b1, 32'd0, 64'd0, 1'b0, 5'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL s1_discard: got v=%b a=%h res=%h w=%b used=%0d expected 1/0/0/0/0",
               rd_valid, rd_operand_a, rd_result, rd_written, entries_used);
    end
    do_read(4'd4);
    n_compared++;
    if ({rd_result, rd_written} !== {64'd0, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_wipe: got res=%h w=%b expected 0/0", rd_result, rd_written);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_r;
    for (int i = 0; i < DEP; i++) do_write(OP_ADD, 32'(i), 32'd100, 4'(i));
    @(negedge clk);
    n_compared++;
    if (entries_used !== 5'd12) begin
      n_mismatched++;
      $display("[TB] FAIL used_full: got %0d expected 12", entries_used);
    end
    for (int i = 0; i < DEP; i++) do_write(OP_SUB, 32'(i), 32'd100, 4'(i));
    @(negedge clk);
    n_compared++;
    if (entries_used !== 5'd12) begin
      n_mismatched++;
      $display("[TB] FAIL used_saturate: got %0d expected 12", entries_used);
    end
    for (int i = 0; i < DEP; i++) begin
      do_read(4'(i));
      exp_r = 64'(i - 100);
      n_compared++;
      if ({rd_opcode, rd_result} !== {OP_SUB, exp_r}) begin
        n_mismatched++;
        $display("[TB] FAIL b2b[%0d]: got op=%0d res=%h expected op=4 res=%h",
                 i, rd_opcode, rd_result, exp_r);
      end
    end
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    reset_n       = 1'b0;
    load_en       = 1'b0;
    opcode        = 3'd0;
    operand_a     = '0;
    operand_b     = '0;
    write_pointer = '0;
    read_en       = 1'b0;
    read_pointer  = '0;
    $display("[TB] starting");
    test_reset();
    test_add();
    test_arith();
    test_div_zero();
    test_same_cycle();
    test_bounds();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
